// File: rtl/output_signature_collector_if.sv
// Handshake and result bundle shared between a kernel harness and the
// output signature collector. The harness side (master) drives the kernel
// control and reduced-data beats. The collector side (slave) returns the
// latched signature, beat count and status.
interface output_signature_collector_if #(
  parameter int SIG_WIDTH = 16,
  parameter int CNT_WIDTH = 16
);
  logic                 ap_start;
  logic                 ap_done;
  logic [3:0]           data_in;
  logic                 data_valid;
  logic [SIG_WIDTH-1:0] sig_out;
  logic [CNT_WIDTH-1:0] beat_count_out;
  logic                 sig_valid;
  logic [7:0]           run_count;
  logic                 busy;
  logic                 overflow;

  modport master (
    output ap_start, ap_done, data_in, data_valid,
    input  sig_out, beat_count_out, sig_valid, run_count, busy, overflow
  );

  modport slave (
    input  ap_start, ap_done, data_in, data_valid,
    output sig_out, beat_count_out, sig_valid, run_count, busy, overflow
  );
endinterface

// File: rtl/output_signature_collector.sv
// Output signature collector.
// Folds every valid 4-bit beat of a kernel run into a rotate/XOR signature.
// A run starts at ap_start. Beats keep being accepted for DRAIN_CYCLES cycles
// after ap_done, so that data still in flight in the output-reduction
// pipeline is included. After that window the signature, beat count and
// saturation flag are latched for software, and sig_valid pulses once.
module output_signature_collector #(
  parameter int                   SIG_WIDTH    = 16,
  parameter int                   CNT_WIDTH    = 16,
  parameter int                   DRAIN_CYCLES = 4,
  parameter logic [SIG_WIDTH-1:0] SIG_SEED     = '0
) (
  input logic                     ap_clk,
  input logic                     ap_rst,
  output_signature_collector_if.slave bus
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t               state;
  logic [SIG_WIDTH-1:0] sig;
  logic [SIG_WIDTH-1:0] sig_next;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 ovf;
  logic                 ovf_next;
  logic [DW-1:0]        drain_cnt;
  logic                 accept;

  logic [SIG_WIDTH-1:0] sig_out_q;
  logic [CNT_WIDTH-1:0] beat_count_q;
  logic                 overflow_q;
  logic                 sig_valid_q;
  logic [7:0]           run_count_q;

  // Next signature/count values if the current beat is accepted; these feed
  // both the running registers and the result latch on the final drain cycle
  always_comb begin
    accept   = bus.data_valid && ((state == COLLECT) || (state == DRAIN));
    sig_next = sig;
    cnt_next = cnt;
    ovf_next = ovf;
    if (accept) begin
      sig_next = {sig[SIG_WIDTH-2:0], sig[SIG_WIDTH-1]} ^
                 {{(SIG_WIDTH-4){1'b0}}, bus.data_in};
      if (&cnt) begin
        ovf_next = 1'b1;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  // Run-control FSM with the accumulators and the latched result registers
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state        <= IDLE;
      sig          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      drain_cnt    <= '0;
      sig_out_q    <= '0;
      beat_count_q <= '0;
      overflow_q   <= 1'b0;
      sig_valid_q  <= 1'b0;
      run_count_q  <= 8'd0;
    end else begin
      sig_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ap_start) begin
            sig       <= SIG_SEED;
            cnt       <= '0;
            ovf       <= 1'b0;
            drain_cnt <= '0;
            state     <= COLLECT;
          end
        end
        COLLECT: begin
          sig <= sig_next;
          cnt <= cnt_next;
          ovf <= ovf_next;
          if (bus.ap_done) begin
            drain_cnt <= DW'(DRAIN_CYCLES);
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          sig       <= sig_next;
          cnt       <= cnt_next;
          ovf       <= ovf_next;
          drain_cnt <= drain_cnt - 1'b1;
          if (drain_cnt == DW'(1)) begin
            sig_out_q    <= sig_next;
            beat_count_q <= cnt_next;
            overflow_q   <= ovf_next;
            run_count_q  <= run_count_q + 8'd1;
            sig_valid_q  <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (bus.ap_start) begin
            sig       <= SIG_SEED;
            cnt       <= '0;
            ovf       <= 1'b0;
            drain_cnt <= '0;
            state     <= COLLECT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sig_out        = sig_out_q;
  assign bus.beat_count_out = beat_count_q;
  assign bus.overflow       = overflow_q;
  assign bus.sig_valid      = sig_valid_q;
  assign bus.run_count      = run_count_q;
  assign bus.busy           = (state == COLLECT) || (state == DRAIN);

endmodule

// File: tb/tb_output_signature_collector.sv
// Testbench for output_signature_collector.
// Two instances share all stimulus: one with default parameters, and one
// with a 4-bit beat counter and a non-zero seed so that saturation can be
// reached. Expected results come from a run-level model: the signature is
// folded over the list of accepted beats, and the count is clamped.
module tb_output_signature_collector;

  localparam int DRAIN = 4;

  logic       ap_clk;
  logic       ap_rst;
  logic       ap_start;
  logic       ap_done;
  logic [3:0] data_in;
  logic       data_valid;

  int n_checks = 0;
  int n_fail   = 0;

  int collect_q[$];
  int drain_q[$];
  int acc_q[$];

  logic [15:0] exp_sig,  exp_sig4;
  logic [15:0] exp_cnt;
  logic [3:0]  exp_cnt4;
  logic        exp_ovf,  exp_ovf4;
  logic [7:0]  exp_runs;

  output_signature_collector_if #(.SIG_WIDTH(16), .CNT_WIDTH(16)) bus ();
  output_signature_collector_if #(.SIG_WIDTH(16), .CNT_WIDTH(4))  bus4 ();

  assign bus.ap_start    = ap_start;
  assign bus.ap_done     = ap_done;
  assign bus.data_in     = data_in;
  assign bus.data_valid  = data_valid;
  assign bus4.ap_start   = ap_start;
  assign bus4.ap_done    = ap_done;
  assign bus4.data_in    = data_in;
  assign bus4.data_valid = data_valid;

  output_signature_collector #(
    .SIG_WIDTH(16), .CNT_WIDTH(16), .DRAIN_CYCLES(DRAIN), .SIG_SEED(16'h0000)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus.slave)
  );

  output_signature_collector #(
    .SIG_WIDTH(16), .CNT_WIDTH(4), .DRAIN_CYCLES(DRAIN), .SIG_SEED(16'h1234)
  ) dut4 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus4.slave)
  );

  // Free-running clock
  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Run-level reference: fold the accepted beats with rotate-left-by-1 then XOR
  function automatic void model_run(input int seed, input int width,
                                    output int s, output int c, output bit o);
    int maxc;
    s = seed;
    foreach (acc_q[i]) begin
      s = ((s * 2) % 65536) + (s / 32768);
      s = s ^ acc_q[i];
    end
    maxc = (1 << width) - 1;
    c = (acc_q.size() > maxc) ? maxc : acc_q.size();
    o = (acc_q.size() > maxc);
  endfunction

  task automatic drive_beat(input int v);
    if (v < 0) begin
      data_valid = 1'b0;
      data_in    = 4'($urandom_range(0, 15));
    end else begin
      data_valid = 1'b1;
      data_in    = 4'(v);
      acc_q.push_back(v);
    end
  endtask

  task automatic apply_reset(input int cycles);
    ap_rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      ap_start   = 1'b1;
      ap_done    = 1'($urandom_range(0, 1));
      data_valid = 1'b1;
      data_in    = 4'($urandom_range(0, 15));
      tick();
    end
    ap_rst     = 1'b0;
    ap_start   = 1'b0;
    ap_done    = 1'b0;
    data_valid = 1'b0;
    exp_sig = '0; exp_sig4 = '0; exp_cnt = '0; exp_cnt4 = '0;
    exp_ovf = 1'b0; exp_ovf4 = 1'b0; exp_runs = 8'd0;
  endtask

  // One complete run using collect_q and drain_q; ap_done rides on the last
  // collect entry, and the cycle after the drain window must be DONE
  task automatic do_run(input bit prestarted, input bit rearm);
    int s, c, s4, c4;
    bit o, o4;
    acc_q.delete();
    if (!prestarted) begin
      ap_start   = 1'b1;
      ap_done    = 1'($urandom_range(0, 1));
      data_valid = 1'b1;
      data_in    = 4'($urandom_range(0, 15));
      tick();
    end
    ap_start = rearm;
    foreach (collect_q[i]) begin
      n_checks++;
      if (bus.busy !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL busy_collect: got %b want 1", bus.busy);
      end
      ap_done = (i == collect_q.size() - 1);
      drive_beat(collect_q[i]);
      tick();
    end
    foreach (drain_q[i]) begin
      n_checks++;
      if (bus.sig_valid !== 1'b0 || bus.busy !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL drain_state: sig_valid=%b busy=%b want 0/1 at drain cycle %0d",
                 bus.sig_valid, bus.busy, i);
      end
      ap_done = 1'($urandom_range(0, 1));
      drive_beat(drain_q[i]);
      tick();
    end
    model_run(16'h0000, 16, s, c, o);
    model_run(16'h1234, 4, s4, c4, o4);
    exp_sig  = 16'(s);  exp_cnt  = 16'(c); exp_ovf  = o;
    exp_sig4 = 16'(s4); exp_cnt4 = 4'(c4); exp_ovf4 = o4;
    exp_runs = exp_runs + 8'd1;
    n_checks++;
    if (bus.sig_valid !== 1'b1 || bus4.sig_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL sig_valid_pulse: got %b/%b want 1/1", bus.sig_valid, bus4.sig_valid);
    end
    n_checks++;
    if (bus.sig_out !== exp_sig || bus.beat_count_out !== exp_cnt || bus.overflow !== exp_ovf) begin
      n_fail++;
      $display("[TB] FAIL result: sig=%h cnt=%0d ovf=%b want sig=%h cnt=%0d ovf=%b",
               bus.sig_out, bus.beat_count_out, bus.overflow, exp_sig, exp_cnt, exp_ovf);
    end
    n_checks++;
    if (bus4.sig_out !== exp_sig4 || bus4.beat_count_out !== exp_cnt4 || bus4.overflow !== exp_ovf4) begin
      n_fail++;
      $display("[TB] FAIL result4: sig=%h cnt=%0d ovf=%b want sig=%h cnt=%0d ovf=%b",
               bus4.sig_out, bus4.beat_count_out, bus4.overflow, exp_sig4, exp_cnt4, exp_ovf4);
    end
    n_checks++;
    if (bus.run_count !== exp_runs || bus4.run_count !== exp_runs || bus.busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL done_status: run_count=%0d/%0d busy=%b want %0d busy=0",
               bus.run_count, bus4.run_count, bus.busy, exp_runs);
    end
    ap_done    = 1'b0;
    data_valid = 1'b1;
    data_in    = 4'($urandom_range(1, 15));
    ap_start   = rearm;
    tick();
    n_checks++;
    if (bus.sig_valid !== 1'b0 || bus.busy !== rearm || bus.sig_out !== exp_sig ||
        bus.beat_count_out !== exp_cnt) begin
      n_fail++;
      $display("[TB] FAIL after_done: sig_valid=%b busy=%b sig=%h cnt=%0d want 0 %b %h %0d",
               bus.sig_valid, bus.busy, bus.sig_out, bus.beat_count_out, rearm, exp_sig, exp_cnt);
    end
    data_valid = 1'b0;
    if (!rearm) ap_start = 1'b0;
  endtask

  task automatic fill_drain_idle();
    drain_q.delete();
    for (int i = 0; i < DRAIN; i++) drain_q.push_back(-1);
  endtask

  task automatic test_reset();
    apply_reset(2);
    n_checks++;
    if (bus.sig_out !== 16'h0 || bus.beat_count_out !== 16'h0 || bus.sig_valid !== 1'b0 ||
        bus.run_count !== 8'd0 || bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: sig=%h cnt=%0d v=%b runs=%0d busy=%b ovf=%b want all 0",
               bus.sig_out, bus.beat_count_out, bus.sig_valid, bus.run_count, bus.busy, bus.overflow);
    end
  endtask

  task automatic test_basic();
    collect_q = '{1, 2, 4, -1};
    fill_drain_idle();
    do_run(1'b0, 1'b0);
    n_checks++;
    if (bus.sig_out !== 16'h0004 || bus.beat_count_out !== 16'd3 || bus.run_count !== 8'd1) begin
      n_fail++;
      $display("[TB] FAIL basic_run: sig=%h cnt=%0d runs=%0d want 0004 3 1",
               bus.sig_out, bus.beat_count_out, bus.run_count);
    end
  endtask

  task automatic test_drain_window();
    collect_q = '{3, -1, 5};
    drain_q   = '{-1, -1, -1, 8};
    do_run(1'b0, 1'b0);
    n_checks++;
    if (bus.sig_out !== 16'h000E || bus.beat_count_out !== 16'd3) begin
      n_fail++;
      $display("[TB] FAIL drain_window: sig=%h cnt=%0d want 000e 3", bus.sig_out, bus.beat_count_out);
    end
  endtask

  task automatic test_idle_ignore();
    for (int i = 0; i < 12; i++) begin
      ap_start   = 1'b0;
      ap_done    = i[0];
      data_valid = ~i[0];
      data_in    = 4'($urandom_range(0, 15));
      tick();
      n_checks++;
      if (bus.busy !== 1'b0 || bus.sig_valid !== 1'b0 || bus.sig_out !== exp_sig ||
          bus.run_count !== exp_runs) begin
        n_fail++;
        $display("[TB] FAIL idle_ignore: busy=%b v=%b sig=%h runs=%0d want 0 0 %h %0d",
                 bus.busy, bus.sig_valid, bus.sig_out, bus.run_count, exp_sig, exp_runs);
      end
    end
    ap_done    = 1'b0;
    data_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    apply_reset(1);
    collect_q = '{int'($urandom_range(0, 15)), int'($urandom_range(0, 15))};
    fill_drain_idle();
    do_run(1'b0, 1'b1);
    collect_q = '{int'($urandom_range(0, 15)), int'($urandom_range(0, 15))};
    do_run(1'b1, 1'b0);
    n_checks++;
    if (bus.beat_count_out !== 16'd2 || bus.run_count !== 8'd2) begin
      n_fail++;
      $display("[TB] FAIL back_to_back: cnt=%0d runs=%0d want 2 2", bus.beat_count_out, bus.run_count);
    end
  endtask

  task automatic test_overflow();
    apply_reset(1);
    collect_q.delete();
    for (int i = 0; i < 20; i++) collect_q.push_back(int'($urandom_range(0, 15)));
    fill_drain_idle();
    do_run(1'b0, 1'b0);
    n_checks++;
    if (bus4.beat_count_out !== 4'd15 || bus4.overflow !== 1'b1 ||
        bus.beat_count_out !== 16'd20 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL overflow: cnt4=%0d ovf4=%b cnt=%0d ovf=%b want 15 1 20 0",
               bus4.beat_count_out, bus4.overflow, bus.beat_count_out, bus.overflow);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    seen = 0;
    apply_reset(1);
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_valid = 1'b1;
      data_in    = 4'($urandom_range(0, 15));
      tick();
    end
    ap_rst     = 1'b1;
    ap_done    = 1'b1;
    data_valid = 1'b1;
    tick();
    ap_rst     = 1'b0;
    ap_done    = 1'b0;
    data_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.sig_valid === 1'b1 || bus4.sig_valid === 1'b1) seen++;
      tick();
    end
    n_checks++;
    if (seen != 0 || bus.run_count !== 8'd0 || bus4.run_count !== 8'd0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_run: pulses=%0d runs=%0d/%0d busy=%b want 0 0/0 0",
               seen, bus.run_count, bus4.run_count, bus.busy);
    end
  endtask

  task automatic test_random_runs();
    bit pre;
    bit re;
    int n;
    apply_reset(1);
    pre = 1'b0;
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(1, 8);
      collect_q.delete();
      for (int i = 0; i < n; i++)
        collect_q.push_back(($urandom_range(0, 9) < 6) ? int'($urandom_range(0, 15)) : -1);
      drain_q.delete();
      for (int i = 0; i < DRAIN; i++)
        drain_q.push_back(($urandom_range(0, 9) < 5) ? int'($urandom_range(0, 15)) : -1);
      re = (r < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
      do_run(pre, re);
      pre = re;
    end
  endtask

  // Test sequence
  initial begin
    ap_rst     = 1'b1;
    ap_start   = 1'b0;
    ap_done    = 1'b0;
    data_valid = 1'b0;
    data_in    = 4'h0;
    test_reset();
    test_basic();
    test_drain_window();
    test_idle_ignore();
    test_back_to_back();
    test_overflow();
    test_reset_mid_run();
    test_random_runs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
